// File: rtl/mem_burst_ctrl.sv
// Burst read/write controller that is the sole master of a single-port word memory.
// Optional write-verify pass (VFY state, sticky err) is enabled with `define VERIFY_WRITE_EN.
module mem_burst_ctrl #(
    parameter int W     = 32,
    parameter int A     = 12,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [A-1:0]     req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [W-1:0]     wr_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_last,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [A-1:0]     mem_addr,
    output logic             mem_write,
    output logic [W-1:0]     mem_wdata,
    input  logic [W-1:0]     mem_rdata
);

    // Every channel uses valid/ready: a transfer happens on a rising edge where both
    // are high; the source holds payload stable while valid is high and ready is low.

`ifdef VERIFY_WRITE_EN
    typedef enum logic [1:0] {IDLE, RD, WR, VFY} state_t;
`else
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
`endif

    state_t           state, state_n;
    logic [A-1:0]     cur_addr;
    logic [LEN_W-1:0] count;
    logic             issue_more;
    logic             addr_vld;
    logic             addr_last;
    logic             wr_fin;
    logic             done_n;
    logic             req_fire, rsp_adv, rd_load, rd_cap, rd_end, wr_fire;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign req_fire  = req_valid && req_ready;

    // Read pipeline: mem_addr holds the beat in flight, rsp_* is the response slot.
    assign rsp_adv = !rsp_valid || rsp_ready;
    assign rd_load = (state == RD) && issue_more && (!addr_vld || rsp_adv);
    assign rd_cap  = (state == RD) && addr_vld && rsp_adv;
    assign rd_end  = (state == RD) && rsp_valid && rsp_ready && rsp_last;

`ifdef VERIFY_WRITE_EN
    assign wr_ready = (state == WR) && !mem_write && !wr_fin;
`else
    assign wr_ready = (state == WR) && !wr_fin;
`endif
    assign wr_fire = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        case (state)
            IDLE: if (req_fire) state_n = req_write ? WR : RD;
            RD: begin
                if (rd_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
`ifdef VERIFY_WRITE_EN
            WR:  if (mem_write) state_n = VFY;
            VFY: begin
                state_n = wr_fin ? IDLE : WR;
                done_n  = wr_fin;
            end
`else
            WR: begin
                if (wr_fin) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr   <= '0;
            count      <= '0;
            issue_more <= 1'b0;
            addr_vld   <= 1'b0;
            addr_last  <= 1'b0;
            wr_fin     <= 1'b0;
            done       <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_last   <= 1'b0;
        end else begin
            done      <= done_n;
            mem_write <= 1'b0;

            if (req_fire) begin
                cur_addr   <= req_addr;
                count      <= req_len;
                issue_more <= !req_write;
                addr_vld   <= 1'b0;
                wr_fin     <= 1'b0;
            end

            if (rd_load) begin
                mem_addr  <= cur_addr;
                addr_vld  <= 1'b1;
                addr_last <= (count == '0);
                cur_addr  <= cur_addr + 1'b1;
                if (count == '0) issue_more <= 1'b0;
                else             count      <= count - 1'b1;
            end else if (rd_cap) begin
                addr_vld <= 1'b0;
            end

            if (rd_cap) begin
                rsp_valid <= 1'b1;
                rsp_data  <= mem_rdata;
                rsp_last  <= addr_last;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_last  <= 1'b0;
            end

            // Address wraps modulo 2**A by plain overflow of cur_addr.
            if (wr_fire) begin
                mem_write <= 1'b1;
                mem_addr  <= cur_addr;
                mem_wdata <= wr_data;
                cur_addr  <= cur_addr + 1'b1;
                if (count == '0) wr_fin <= 1'b1;
                else             count  <= count - 1'b1;
            end
        end
    end

`ifdef VERIFY_WRITE_EN
    logic err_q;

    // mem_addr/mem_wdata still hold the just-written beat during VFY.
    always_ff @(posedge clk) begin
        if (rst)                                          err_q <= 1'b0;
        else if (req_fire)                                err_q <= 1'b0;
        else if ((state == VFY) && (mem_rdata != mem_wdata)) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: memory model, per-cycle scoreboard, literal pins.
module tb_mem_burst_ctrl;

    localparam int W     = 32;
    localparam int A     = 12;
    localparam int LEN_W = 8;
    localparam int DEPTH = 1 << A;

    logic             clk, rst;
    logic             req_valid, req_ready, req_write;
    logic [A-1:0]     req_addr;
    logic [LEN_W-1:0] req_len;
    logic             wr_valid, wr_ready;
    logic [W-1:0]     wr_data;
    logic             rsp_valid, rsp_ready, rsp_last;
    logic [W-1:0]     rsp_data;
    logic             busy, done, err;
    logic [A-1:0]     mem_addr;
    logic             mem_write;
    logic [W-1:0]     mem_wdata, mem_rdata;

    mem_burst_ctrl #(.W(W), .A(A), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---- memory attached to the DUT ----
    logic [W-1:0] bmem   [0:DEPTH-1];
    logic [W-1:0] shadow [0:DEPTH-1];
    assign mem_rdata = bmem[mem_addr];
    always @(posedge clk) if (mem_write) bmem[mem_addr] <= mem_wdata;

    // ---- scoreboard state ----
    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int wcnt = 0;
    logic [A+W-1:0] exp_wq[$];
    logic [W:0]     exp_rq[$];
    logic [W:0]     rsp_log[$];
    logic [W-1:0]   wdat [0:7];
    int             gaps_tab [0:3] = '{0, 2, 0, 1};

    // ---- response backpressure ----
    logic        rdy_mode = 1'b0;
    logic [3:0]  pat = 4'b1001;
    int unsigned k = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_mode) begin
            rsp_ready = pat[k % 4];
            k++;
        end else begin
            rsp_ready = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // ---- per-cycle compare process ----
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_last;
    always @(negedge clk) begin
        logic [A+W-1:0] ew;
        logic [W:0]     er;
        chk("busy_vs_ready", busy, !req_ready);
        chk("err_low", err, 1'b0);
        if (done === 1'b1) begin
            done_cnt++;
            chk("done_idle", {busy, req_ready}, 2'b01);
        end
        if (mem_write === 1'b1) begin
            wcnt++;
            if (exp_wq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_write: got addr=%0h data=%0h expected no write", mem_addr, mem_wdata);
            end else begin
                ew = exp_wq.pop_front();
                chk("wr_addr", mem_addr, ew[A+W-1:W]);
                chk("wr_data", mem_wdata, ew[W-1:0]);
            end
        end
        if (prev_stall)
            chk("stall_hold", {rsp_valid, rsp_last, rsp_data}, {1'b1, prev_last, prev_data});
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            rsp_log.push_back({rsp_last, rsp_data});
            if (exp_rq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_rsp: got data=%0h expected no beat", rsp_data);
            end else begin
                er = exp_rq.pop_front();
                chk("rsp_beat", {rsp_last, rsp_data}, er);
            end
        end
        prev_stall = (rsp_valid === 1'b1) && (rsp_ready === 1'b0);
        prev_data  = rsp_data;
        prev_last  = rsp_last;
    end

    // ---- driver tasks ----
    task automatic send_req(input logic wr, input int addr, input int len, output int acc);
        bit hs = 1'b0;
        acc = -1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr[A-1:0];
        req_len   = len[LEN_W-1:0];
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            if (req_ready) hs = 1'b1;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        chk("req_accepted", hs, 1'b1);
        if (hs) begin
            acc = cyc;
            if (!wr)
                for (int i = 0; i <= len; i++)
                    exp_rq.push_back({(i == len), shadow[(addr + i) % DEPTH]});
        end
    endtask

    task automatic wr_beats(input int addr, input int n, input bit gap_mode);
        for (int i = 0; i < n; i++) begin
            bit hs = 1'b0;
            int a = (addr + i) % DEPTH;
            wr_valid = 1'b0;
            if (gap_mode) repeat (gaps_tab[i % 4]) begin @(posedge clk); #1; end
            wr_valid = 1'b1;
            wr_data  = wdat[i];
            for (int j = 0; j < 50 && !hs; j++) begin
                @(negedge clk);
                if (wr_ready) hs = 1'b1;
                @(posedge clk);
                #1;
            end
            if (!hs) chk("wr_beat_accepted", hs, 1'b1);
            else begin
                exp_wq.push_back({a[A-1:0], wdat[i]});
                shadow[a] = wdat[i];
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(nm, seen, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_ctrl"}, {req_ready, wr_ready, rsp_valid, rsp_last, busy, done, err, mem_write},
            8'b1000_0000);
        chk({nm, "_mem_addr"}, mem_addr, '0);
        chk({nm, "_mem_wdata"}, mem_wdata, '0);
        chk({nm, "_rsp_data"}, rsp_data, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---- directed sequence ----
    initial begin
        int acc, n, wc0, dc0;
        bit seen;
        for (int i = 0; i < DEPTH; i++) begin
            bmem[i]   = {20'hA5A5A, i[11:0]};
            shadow[i] = {20'hA5A5A, i[11:0]};
        end
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0;

        // reset with random inputs
        repeat (2) begin
            @(posedge clk);
            #1;
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = A'($urandom_range(0, DEPTH - 1));
            req_len   = LEN_W'($urandom_range(0, 255));
            wr_valid  = 1'($urandom_range(0, 1));
            wr_data   = $urandom;
            @(negedge clk);
            check_reset_outputs("reset");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        wr_valid  = 1'b0;
        chk("reset_no_write", wcnt, 0);

        // single write then read
        wdat[0] = 32'hDEADBEEF;
        send_req(1'b1, 5, 0, acc);
        wr_beats(5, 1, 1'b0);
        wait_done("wr1_done");
        chk("wr1_mem5", bmem[5], 32'hDEADBEEF);
        chk("wr1_pulses", wcnt, 1);
        chk("wr1_done_cnt", done_cnt, 1);

        rsp_log.delete();
        send_req(1'b0, 5, 0, acc);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("rd1_latency", cyc - acc, 2);
        wait_done("rd1_done");
        chk("rd1_beat", rsp_log[0], {1'b1, 32'hDEADBEEF});

        // wrapping burst
        wdat[0] = 32'd1; wdat[1] = 32'd2; wdat[2] = 32'd3; wdat[3] = 32'd4;
        send_req(1'b1, 4094, 3, acc);
        wr_beats(4094, 4, 1'b0);
        wait_done("wrap_wr_done");
        chk("wrap_m4094", bmem[4094], 32'd1);
        chk("wrap_m4095", bmem[4095], 32'd2);
        chk("wrap_m0", bmem[0], 32'd3);
        chk("wrap_m1", bmem[1], 32'd4);
        rsp_log.delete();
        send_req(1'b0, 4094, 3, acc);
        wait_done("wrap_rd_done");
        chk("wrap_rd_n", rsp_log.size(), 4);
        chk("wrap_rd0", rsp_log[0], {1'b0, 32'd1});
        chk("wrap_rd1", rsp_log[1], {1'b0, 32'd2});
        chk("wrap_rd2", rsp_log[2], {1'b0, 32'd3});
        chk("wrap_rd3", rsp_log[3], {1'b1, 32'd4});

        // backpressured read
        dc0 = done_cnt;
        rsp_log.delete();
        k = 0;
        rdy_mode = 1'b1;
        send_req(1'b0, 16, 7, acc);
        wait_done("bp_done");
        rdy_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_beats", rsp_log.size(), 8);
        chk("bp_first", rsp_log[0], {1'b0, 32'hA5A5A010});
        chk("bp_last", rsp_log[7], {1'b1, 32'hA5A5A017});
        chk("bp_done_once", done_cnt - dc0, 1);
        @(posedge clk);
        #1;

        // write with wr_valid gaps and a request held while busy
        wdat[0] = 32'h1111_0001; wdat[1] = 32'h2222_0002;
        wdat[2] = 32'h3333_0003; wdat[3] = 32'h4444_0004;
        wc0 = wcnt;
        dc0 = done_cnt;
        send_req(1'b1, 200, 3, acc);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 12'd7;
        req_len   = 8'd0;
        wr_beats(200, 4, 1'b1);
        req_valid = 1'b0;
        wait_done("gap_done");
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("ignored_req_idle", busy, 1'b0);
        chk("gap_pulses", wcnt - wc0, 4);
        chk("gap_m202", bmem[202], 32'h3333_0003);
        chk("gap_done_once", done_cnt - dc0, 1);
        @(posedge clk);
        #1;

        // reset during beat 3 of an 8-beat write
        for (int i = 0; i < 8; i++) wdat[i] = 32'hC0DE_0000 + i;
        wc0 = wcnt;
        dc0 = done_cnt;
        send_req(1'b1, 100, 7, acc);
        wr_beats(100, 2, 1'b0);
        wr_valid = 1'b1;
        wr_data  = wdat[2];
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        repeat (5) @(negedge clk);
        n = wcnt - wc0;
        chk("rst_mid_pulses", (n >= 2 && n <= 3), 1'b1);
        chk("rst_mid_no_done", done_cnt - dc0, 0);
        chk("rst_mid_q", exp_wq.size(), 0);
        @(posedge clk);
        #1;

        // data written before the abort is intact
        rsp_log.delete();
        send_req(1'b0, 100, 1, acc);
        wait_done("post_rst_rd_done");
        chk("post_rst_rd1", rsp_log[1], {1'b1, 32'hC0DE_0001});
        chk("rsp_q_empty", exp_rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
